// File: rtl/pwm_multi_channel_gen_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel_gen_if
//
// Configuration bus between the AXI register file (master) and the
// multi-channel PWM generator (slave). Signal prefixes follow the direction
// as seen from the PWM block: i_ signals flow into the generator and o_
// signals flow back to the register file.
//
// Signals:
//   i_cfg_wr_en    1      one-cycle configuration write strobe
//   i_cfg_wr_sel   2      write target: 0=duty, 1=phase, 2=period, 3=divider
//   i_cfg_wr_ch    4      channel index for duty/phase writes
//   i_cfg_wr_data  DIV_W  write data (low CNT_W bits used for duty/phase/period)
//   o_cfg_pending  1      staged configuration not yet applied
//
// Modports:
//   master  register-file side, drives the write strobe and data
//   slave   PWM generator side, returns the pending flag
// ---------------------------------------------------------------------------
interface pwm_multi_channel_gen_if #(
    parameter int DIV_W = 16
) ();

    logic             i_cfg_wr_en;
    logic [1:0]       i_cfg_wr_sel;
    logic [3:0]       i_cfg_wr_ch;
    logic [DIV_W-1:0] i_cfg_wr_data;
    logic             o_cfg_pending;

    modport master (
        output i_cfg_wr_en,
        output i_cfg_wr_sel,
        output i_cfg_wr_ch,
        output i_cfg_wr_data,
        input  o_cfg_pending
    );

    modport slave (
        input  i_cfg_wr_en,
        input  i_cfg_wr_sel,
        input  i_cfg_wr_ch,
        input  i_cfg_wr_data,
        output o_cfg_pending
    );

endinterface

// File: rtl/pwm_multi_channel_gen.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel_gen
//
// Generates NUM_CH independent PWM outputs from one shared prescaler and one
// shared period counter. Each channel has its own duty cycle and phase
// offset. All configuration is double-buffered: writes land in staging
// registers and are copied into the active registers only when the period
// counter wraps, so a running waveform never sees a half-applied setting.
//
// Parameters:
//   NUM_CH  number of PWM channels (1..16)
//   CNT_W   width of period, duty and phase values
//   DIV_W   width of the prescaler divide value (must be >= CNT_W)
//
// Ports:
//   i_clk           single clock
//   i_rst           synchronous, active-high reset
//   i_en            global run enable
//   cfg             configuration bus (slave modport): write strobe, target
//                   select, channel, data, and the cfg_pending status flag
//   o_pwm_out       registered PWM outputs, one bit per channel
//   o_period_start  one-cycle pulse at the start of every period
//
// Timing summary:
//   Period length  = (period+1) * (div+1) clock cycles.
//   High time      = duty * (div+1) clock cycles for duty <= period.
//   o_pwm_out is registered: its value in cycle t+1 is computed from the
//   counter and active settings of cycle t.
// ---------------------------------------------------------------------------
module pwm_multi_channel_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    pwm_multi_channel_gen_if.slave    cfg,
    output logic [NUM_CH-1:0]         o_pwm_out,
    output logic                      o_period_start
);

    // Write target encodings on the configuration bus.
    localparam logic [1:0] SEL_DUTY   = 2'd0;
    localparam logic [1:0] SEL_PHASE  = 2'd1;
    localparam logic [1:0] SEL_PERIOD = 2'd2;

    // Channel count widened to 5 bits so that NUM_CH=16 still compares
    // correctly against the 4-bit channel index.
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    // Unit increments sized to their counters.
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   EXT_ONE = {{CNT_W{1'b0}}, 1'b1};

    // Staging registers, written directly by the configuration bus.
    logic [CNT_W-1:0] r_dutyS  [NUM_CH];
    logic [CNT_W-1:0] r_phaseS [NUM_CH];
    logic [CNT_W-1:0] r_periodS;
    logic [DIV_W-1:0] r_divS;

    // Active registers, the values the counters and comparators really use.
    logic [CNT_W-1:0] r_dutyA  [NUM_CH];
    logic [CNT_W-1:0] r_phaseA [NUM_CH];
    logic [CNT_W-1:0] r_periodA;
    logic [DIV_W-1:0] r_divA;

    // Counters, status and registered outputs.
    logic [DIV_W-1:0]  r_preCnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic              r_enPrev;
    logic [NUM_CH-1:0] r_pwmOut;
    logic              r_periodStart;

    // Combinational helpers.
    logic              w_tick;
    logic              w_wrap;
    logic              w_chValid;
    logic              w_wrAccept;
    logic [CNT_W-1:0]  w_wrData;
    logic [CNT_W-1:0]  w_phaseClamped;
    logic [NUM_CH-1:0] w_pwmNext;

    // The prescaler ticks on its terminal count; the period wraps when a
    // tick arrives while the period counter sits on its terminal count.
    assign w_tick = (r_preCnt == r_divA);
    assign w_wrap = w_tick && (r_cnt == r_periodA);

    // Duty/phase writes to a channel that does not exist are dropped and
    // must not disturb cfg_pending. Period and divider writes ignore the
    // channel field entirely.
    assign w_chValid  = ({1'b0, cfg.i_cfg_wr_ch} < NUM_CH_L);
    assign w_wrAccept = cfg.i_cfg_wr_en && (cfg.i_cfg_wr_sel[1] || w_chValid);
    assign w_wrData   = cfg.i_cfg_wr_data[CNT_W-1:0];

    // A phase beyond the staged period is meaningless, so it is clamped to
    // the staged period at the moment it is written.
    assign w_phaseClamped = (w_wrData > r_periodS) ? r_periodS : w_wrData;

    // Per-channel comparator. The counter is shifted by the phase offset and
    // folded back into 0..period with one extra bit of headroom so the sum
    // cannot overflow. A duty of 0 never matches (constant low) and a duty
    // above the period always matches (constant high).
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W:0] w_phaseSum;
        logic [CNT_W:0] w_pos;

        assign w_phaseSum   = {1'b0, r_cnt} + {1'b0, r_phaseA[g]};
        assign w_pos        = (w_phaseSum > {1'b0, r_periodA})
                            ? (w_phaseSum - ({1'b0, r_periodA} + EXT_ONE))
                            : w_phaseSum;
        assign w_pwmNext[g] = (w_pos < {1'b0, r_dutyA[g]});
    end

    // Staging registers accept writes at any time, running or idle. Duty and
    // phase writes are steered by comparing the channel field against each
    // channel number, so an out-of-range index simply matches nothing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_dutyS[c]  <= '0;
                r_phaseS[c] <= '0;
            end
            r_periodS <= '0;
            r_divS    <= '0;
        end else if (cfg.i_cfg_wr_en) begin
            case (cfg.i_cfg_wr_sel)
                SEL_DUTY: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cfg.i_cfg_wr_ch == 4'(c)) begin
                            r_dutyS[c] <= w_wrData;
                        end
                    end
                end
                SEL_PHASE: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cfg.i_cfg_wr_ch == 4'(c)) begin
                            r_phaseS[c] <= w_phaseClamped;
                        end
                    end
                end
                SEL_PERIOD: begin
                    r_periodS <= w_wrData;
                end
                default: begin
                    r_divS <= cfg.i_cfg_wr_data;
                end
            endcase
        end
    end

    // Active registers follow staging continuously while idle, and only at
    // the period wrap while running. The copy uses the staging contents from
    // before any write in the same cycle, so a write colliding with the wrap
    // waits a full period before it takes effect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_dutyA[c]  <= '0;
                r_phaseA[c] <= '0;
            end
            r_periodA <= '0;
            r_divA    <= '0;
        end else if (!i_en || w_wrap) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_dutyA[c]  <= r_dutyS[c];
                r_phaseA[c] <= r_phaseS[c];
            end
            r_periodA <= r_periodS;
            r_divA    <= r_divS;
        end
    end

    // Prescaler and period counter. Both are held at zero while idle so that
    // every enable starts a fresh period from count 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_preCnt <= '0;
            r_cnt    <= '0;
        end else begin
            r_preCnt <= w_tick ? '0 : (r_preCnt + DIV_ONE);
            if (w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // cfg_pending rises on any accepted write and falls at the wrap that
    // applies it. An accepted write wins over the wrap because the colliding
    // write is still waiting in staging. While idle the active registers
    // track staging, so nothing can be pending.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_pending <= 1'b0;
        end else if (w_wrAccept) begin
            r_pending <= 1'b1;
        end else if (w_wrap) begin
            r_pending <= 1'b0;
        end
    end

    // Remembers the previous enable so the first running cycle can announce
    // a period start even though no wrap has happened yet.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enPrev <= 1'b0;
        end else begin
            r_enPrev <= i_en;
        end
    end

    // Registered outputs. Dropping enable or asserting reset forces every
    // output low on the very next edge, cutting any pulse in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_pwmOut      <= '0;
            r_periodStart <= 1'b0;
        end else begin
            r_pwmOut      <= w_pwmNext;
            r_periodStart <= w_wrap || !r_enPrev;
        end
    end

    assign o_pwm_out         = r_pwmOut;
    assign o_period_start    = r_periodStart;
    assign cfg.o_cfg_pending = r_pending;

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel_gen
//
// Directed bench for pwm_multi_channel_gen with NUM_CH=4, CNT_W=8, DIV_W=16.
// A table of per-cycle records drives the basic duty scenario; hand-written
// sequences cover double buffering, write/wrap collision, duty and phase
// boundaries, dropped writes, phase offset with a prescaler, and reset.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 16;

    typedef struct {
        logic        wrEn;
        logic [1:0]  sel;
        logic [3:0]  ch;
        logic [15:0] data;
        logic        en;
        logic [3:0]  expPwm;
        logic        expPs;
        logic        expPend;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [NUM_CH-1:0] pwm;
    logic              ps;

    int checks;
    int failures;

    vec_t vecs [34];
    logic s0 [0:32];
    logic s1 [0:32];
    logic psS [0:32];

    pwm_multi_channel_gen_if #(.DIV_W(DIV_W)) cfg ();

    pwm_multi_channel_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DIV_W  (DIV_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .cfg            (cfg),
        .o_pwm_out      (pwm),
        .o_period_start (ps)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one table record for a single clock edge.
    task automatic applyStimulus(input vec_t v);
        cfg.i_cfg_wr_en   = v.wrEn;
        cfg.i_cfg_wr_sel  = v.sel;
        cfg.i_cfg_wr_ch   = v.ch;
        cfg.i_cfg_wr_data = v.data;
        en                = v.en;
        tick();
        cfg.i_cfg_wr_en   = 1'b0;
    endtask

    // One-cycle configuration write.
    task automatic writeCfg(input logic [1:0] sel, input logic [3:0] ch,
                            input logic [15:0] data);
        cfg.i_cfg_wr_sel  = sel;
        cfg.i_cfg_wr_ch   = ch;
        cfg.i_cfg_wr_data = data;
        cfg.i_cfg_wr_en   = 1'b1;
        tick();
        cfg.i_cfg_wr_en   = 1'b0;
    endtask

    initial begin
        int rise0;
        int rise1;
        int highs;
        logic ch3Exp;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        cfg.i_cfg_wr_en   = 1'b0;
        cfg.i_cfg_wr_sel  = 2'd0;
        cfg.i_cfg_wr_ch   = 4'd0;
        cfg.i_cfg_wr_data = 16'd0;

        // Basic duty table: idle writes of period=9, div=0, duty0=3, one idle
        // cycle for the active copy, then 30 running cycles. Channel 0 is high
        // for counts 0..2 of every 10-count period; period_start fires one
        // cycle after enable and then after every wrap.
        vecs[0] = '{1'b1, 2'd2, 4'd0, 16'd9, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'd3, 4'd0, 16'd0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 4'd0, 16'd3, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 4'd0, 16'd0, 1'b0, 4'h0, 1'b0, 1'b0};
        for (int i = 1; i <= 30; i++) begin
            vecs[3+i] = '{1'b0, 2'd0, 4'd0, 16'd0, 1'b1,
                          {3'b000, logic'(((i - 1) % 10) < 3)},
                          logic'((i == 1) || ((i % 10) == 0)), 1'b0};
        end

        // Reset state.
        tick();
        tick();
        checkOutput("reset pwm", pwm, 0);
        checkOutput("reset period_start", ps, 0);
        checkOutput("reset pending", cfg.o_cfg_pending, 0);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d pwm", i), pwm, vecs[i].expPwm);
            checkOutput($sformatf("vec%0d period_start", i), ps, vecs[i].expPs);
            checkOutput($sformatf("vec%0d pending", i), cfg.o_cfg_pending, vecs[i].expPend);
        end

        // Double buffering: counter is at 0 after the last record. Write
        // duty0=8 at count 3; old duty stays in force until the wrap.
        repeat (3) tick();
        writeCfg(2'd0, 4'd0, 16'd8);
        checkOutput("dbuf pending set", cfg.o_cfg_pending, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("dbuf hold pending %0d", k), cfg.o_cfg_pending, 1);
            checkOutput($sformatf("dbuf old pwm %0d", k), pwm[0], 0);
        end
        tick();
        checkOutput("dbuf wrap period_start", ps, 1);
        checkOutput("dbuf wrap pending clear", cfg.o_cfg_pending, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("dbuf new pwm %0d", k), pwm[0], logic'(k <= 8));
            checkOutput($sformatf("dbuf ps %0d", k), ps, logic'(k == 10));
        end

        // Collision: write duty0=2 on the wrap edge. Duty 8 runs one more
        // period with pending held, then duty 2 applies.
        repeat (9) tick();
        writeCfg(2'd0, 4'd0, 16'd2);
        checkOutput("coll period_start", ps, 1);
        checkOutput("coll pending kept", cfg.o_cfg_pending, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("coll old pwm %0d", k), pwm[0], logic'(k <= 8));
            checkOutput($sformatf("coll pending %0d", k), cfg.o_cfg_pending, logic'(k < 10));
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("coll new pwm %0d", k), pwm[0], logic'(k <= 2));
        end

        // Boundaries: ch0 duty 0, ch1 duty 10, ch2 duty 255, ch3 duty 5 with
        // phase 20 clamped to 9 (high for counts 1..5). Dropped writes to
        // channels 4 and 15 must change neither pending nor any channel.
        en = 1'b0;
        tick();
        writeCfg(2'd0, 4'd0, 16'd0);
        writeCfg(2'd0, 4'd1, 16'd10);
        writeCfg(2'd0, 4'd2, 16'd255);
        writeCfg(2'd0, 4'd3, 16'd5);
        writeCfg(2'd1, 4'd3, 16'd20);
        tick();
        tick();
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) begin
                cfg.i_cfg_wr_sel  = 2'd0;
                cfg.i_cfg_wr_ch   = 4'd4;
                cfg.i_cfg_wr_data = 16'd7;
                cfg.i_cfg_wr_en   = 1'b1;
            end else if (k == 22) begin
                cfg.i_cfg_wr_sel  = 2'd1;
                cfg.i_cfg_wr_ch   = 4'd15;
                cfg.i_cfg_wr_data = 16'd3;
                cfg.i_cfg_wr_en   = 1'b1;
            end else begin
                cfg.i_cfg_wr_en   = 1'b0;
            end
            tick();
            ch3Exp = logic'((((k - 1) % 10) >= 1) && (((k - 1) % 10) <= 5));
            checkOutput($sformatf("bound pwm %0d", k), pwm, {ch3Exp, 3'b110});
            checkOutput($sformatf("bound ps %0d", k), ps, logic'((k == 1) || ((k % 10) == 0)));
            if (k == 21 || k == 22) begin
                checkOutput($sformatf("drop pending %0d", k), cfg.o_cfg_pending, 0);
            end
        end
        cfg.i_cfg_wr_en = 1'b0;

        // Phase offset: period 7, div 1, duty 4 on ch0 and ch1, phase 2 on
        // ch1. Each count lasts two cycles, so ch1 rises 4 cycles before ch0.
        en = 1'b0;
        tick();
        writeCfg(2'd2, 4'd0, 16'd7);
        writeCfg(2'd3, 4'd0, 16'd1);
        writeCfg(2'd0, 4'd0, 16'd4);
        writeCfg(2'd0, 4'd1, 16'd4);
        writeCfg(2'd0, 4'd2, 16'd0);
        writeCfg(2'd0, 4'd3, 16'd0);
        writeCfg(2'd1, 4'd1, 16'd2);
        tick();
        tick();
        en = 1'b1;
        s0[0] = 1'b0;
        s1[0] = 1'b0;
        psS[0] = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            s0[k]  = pwm[0];
            s1[k]  = pwm[1];
            psS[k] = ps;
        end
        rise0 = -1;
        rise1 = -1;
        highs = 0;
        for (int k = 2; k <= 32; k++) begin
            if (rise0 < 0 && s0[k] && !s0[k-1]) rise0 = k;
            if (rise1 < 0 && s1[k] && !s1[k-1]) rise1 = k;
        end
        for (int k = 17; k <= 32; k++) begin
            highs += int'(s0[k]);
        end
        checkOutput("phase ch1 rise", rise1, 13);
        checkOutput("phase ch0 rise", rise0, 17);
        checkOutput("phase ch0 high time", highs, 8);
        checkOutput("phase ps at 15", psS[15], 0);
        checkOutput("phase ps at 16", psS[16], 1);
        checkOutput("phase ps at 32", psS[32], 1);

        // Reset during a high pulse clears everything; the block then stays
        // low until a duty is programmed again.
        en = 1'b0;
        tick();
        writeCfg(2'd2, 4'd0, 16'd9);
        writeCfg(2'd3, 4'd0, 16'd0);
        writeCfg(2'd0, 4'd0, 16'd5);
        writeCfg(2'd0, 4'd1, 16'd0);
        tick();
        tick();
        en = 1'b1;
        repeat (3) tick();
        checkOutput("rst pre high", pwm[0], 1);
        rst = 1'b1;
        tick();
        checkOutput("rst pwm", pwm, 0);
        checkOutput("rst period_start", ps, 0);
        checkOutput("rst pending", cfg.o_cfg_pending, 0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("rst stays low %0d", k), pwm, 0);
        end
        // Period is 0 after reset, so every cycle wraps: this write collides
        // with a wrap and applies one cycle later.
        writeCfg(2'd0, 4'd0, 16'd1);
        checkOutput("reprog pending", cfg.o_cfg_pending, 1);
        tick();
        checkOutput("reprog pending clear", cfg.o_cfg_pending, 0);
        tick();
        checkOutput("reprog pwm high", pwm[0], 1);

        // Enable falling cuts the output on the next edge; re-enable restarts.
        en = 1'b0;
        tick();
        checkOutput("en fall pwm", pwm, 0);
        checkOutput("en fall ps", ps, 0);
        en = 1'b1;
        tick();
        checkOutput("re-enable pwm", pwm[0], 1);
        checkOutput("re-enable ps", ps, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel_gen.md
# pwm_multi_channel_gen

Parametrised successor to the single-channel PWM block in the neuromorphic ASIC bridge. It generates NUM_CH independent PWM outputs from one shared prescaler and period counter, with per-channel duty cycle and phase offset. Configuration is double-buffered, so new settings take effect only at a period boundary. The AXI register file drives it, and its outputs feed the ASIC stimulus pins and debug LEDs.

## Interface
- NUM_CH, 4, number of PWM channels (1..16)
- CNT_W, 8, width of period, duty and phase values
- DIV_W, 16, width of the prescaler divide value
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global run enable
- cfg_wr_en  in  1  one-cycle config write strobe
- cfg_wr_sel  in  2  target: 0=duty, 1=phase, 2=period, 3=divider
- cfg_wr_ch  in  4  channel index for duty/phase writes (ignored for sel 2/3)
- cfg_wr_data  in  DIV_W  write data; the low CNT_W bits are used for sel 0..2
- pwm_out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse in the first cycle of each period
- cfg_pending  out  1  staging differs from active, awaiting a boundary

## Operation
- Staging registers: duty_s[ch], phase_s[ch], period_s, div_s. Active registers: duty_a, phase_a, period_a, div_a. All reset to 0.
- Write handling: when cfg_wr_en=1, the selected staging register loads and cfg_pending is set. Writes with cfg_wr_ch >= NUM_CH are dropped and leave cfg_pending unchanged.
- Phase clamp: a phase write whose value exceeds period_s is clamped to period_s when written into staging.
- Prescaler pre_cnt (DIV_W bits): counts 0..div_a. tick=1 when pre_cnt==div_a, after which pre_cnt wraps to 0. div_a=0 gives a tick every cycle.
- Period counter cnt (CNT_W bits): advances on tick over 0..period_a. wrap = tick && cnt==period_a, which sets cnt to 0.
- Active load: on wrap, all active registers load from staging and cfg_pending clears.
- Write/wrap collision: a write in the same cycle as wrap lands in staging only. The active load uses the pre-write staging, and cfg_pending remains 1.
- Per-channel output:
  - p = cnt + phase_a[ch], evaluated with CNT_W+1 bits; if p > period_a, then p -= period_a+1.
  - Next pwm_out[ch] = (p < duty_a[ch]).
  - duty=0 gives constant low. duty > period_a gives constant high (100%).
- Idle (en=0): pre_cnt=0, cnt=0, pwm_out=0, period_start=0. Active registers copy staging every cycle, and cfg_pending reads 0.
- Start (en rising): counting begins from cnt=0. period_start pulses one cycle after the first en=1 cycle.

## Timing
- Reset values: pwm_out=0, period_start=0, cfg_pending=0, all counters and registers 0.
- Output latency: pwm_out is registered, so pwm_out(t+1) = f(cnt(t), active(t)).
- period_start: asserted in the cycle after wrap (aligned with cnt=0), and one cycle after enable.
- Period length: (period_a+1)·(div_a+1) clk cycles.
- Duty resolution: high time = duty·(div_a+1) cycles, for duty <= period_a.
- Reset mid-period: takes effect on the next edge. Staging, active and outputs all clear, and no partial pulse is emitted afterwards.
- en falling mid-period: pwm_out goes low on the next edge. The counter restarts from 0 on re-enable.

## Test plan
- Basic duty
  - Stimulus: while en=0, write period=9, div=0, duty[0]=3; then en=1.
  - Required: pwm_out[0] is high for 3 cycles and low for 7, repeating every 10 cycles. period_start pulses every 10 cycles.
- Phase offset
  - Stimulus: period=7, div=1, duty[0]=duty[1]=4, phase[1]=2.
  - Required: ch1 rising edge is 4 clk cycles before ch0's, i.e. 2 counts × 2.
- Double buffering
  - Stimulus: while running (period=9), write duty[0]=8 mid-period.
  - Required: cfg_pending=1 until the next wrap. The new 8-cycle high time starts exactly at the following period_start.
- Collision
  - Stimulus: write duty in the same cycle as wrap.
  - Required: the old duty is used for the next period, cfg_pending stays 1, and the new duty applies one period later.
- Boundaries
  - duty=0: constant low.
  - duty=period+1 or 255 with period=9: constant high.
  - phase write of 20 with period_s=9: reads back as 9.
  - Write to cfg_wr_ch=NUM_CH: no effect.
- Reset and enable
  - Stimulus: assert rst mid-high-pulse.
  - Required: pwm_out=0 on the next edge and all registers are 0. After re-enable, outputs stay low until duty is reprogrammed.
